mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_load_ext.sv | 20 ++
 rtl/mem_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: memop encodings, FSM states,
// pipeline-wide constants and small decode helpers.
package mem_stage_pkg;

   localparam logic [3:0] MEMOP_NONE = 4'd0;
   localparam logic [3:0] MEMOP_LB   = 4'd1;
   localparam logic [3:0] MEMOP_LH   = 4'd2;
   localparam logic [3:0] MEMOP_LW   = 4'd3;
   localparam logic [3:0] MEMOP_LBU  = 4'd4;
   localparam logic [3:0] MEMOP_LHU  = 4'd5;
   localparam logic [3:0] MEMOP_SB   = 4'd6;
   localparam logic [3:0] MEMOP_SH   = 4'd7;
   localparam logic [3:0] MEMOP_SW   = 4'd8;

   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        RST_DISABLE   = 1'b0;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic logic is_store(input logic [3:0] op);
      return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
   endfunction

   // Index of the final byte of the access (nbytes - 1).
   function automatic logic [1:0] last_idx(input logic [3:0] op);
      case (op)
         MEMOP_LB, MEMOP_LBU, MEMOP_SB: return 2'd0;
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2'd1;
         default:                       return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result formatter: sign/zero extension of the assembled load bytes.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] bytes,
   output logic [31:0] value
);

   always_comb begin
      case (op)
         MEMOP_LB:  value = {{24{bytes[7]}}, bytes[7:0]};
         MEMOP_LH:  value = {{16{bytes[15]}}, bytes[15:0]};
         MEMOP_LBU: value = {24'h000000, bytes[7:0]};
         MEMOP_LHU: value = {16'h0000, bytes[15:0]};
         default:   value = bytes;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-serial loads/stores through the memory
// controller, stalling the pipeline until the access completes.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  ex_memop,
   input  logic [31:0] ex_result,
   input  logic [31:0] ex_storedata,
   input  logic [4:0]  ex_rd,
   input  logic        ex_wreg,
   output logic        mctl_req,
   output logic        mctl_wr,
   output logic [31:0] mctl_addr,
   output logic [7:0]  mctl_wdata,
   input  logic        mctl_ack,
   input  logic [7:0]  mctl_rdata,
   output logic        mem_wreg,
   output logic [4:0]  mem_rd,
   output logic [31:0] mem_wdata,
   output logic        stall_req
);

   state_t      state_reg, state_next;
   logic [1:0]  idx_reg, idx_next;
   logic [31:0] byte_buf_reg, byte_buf_next;
   logic [3:0]  op_reg, op_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] sdata_reg, sdata_next;
   logic [4:0]  rd_reg, rd_next;
   logic        wreg_reg, wreg_next;
   logic [31:0] load_value;

   mem_load_ext u_load_ext (
      .op    (op_reg),
      .bytes (byte_buf_reg),
      .value (load_value)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in == RST_ENABLE) begin
         state_reg    <= ST_IDLE;
         idx_reg      <= 2'd0;
         byte_buf_reg <= ZERO_WORD;
         op_reg       <= MEMOP_NONE;
         addr_reg     <= ZERO_WORD;
         sdata_reg    <= ZERO_WORD;
         rd_reg       <= 5'd0;
         wreg_reg     <= WRITE_DISABLE;
      end else begin
         state_reg    <= state_next;
         idx_reg      <= idx_next;
         byte_buf_reg <= byte_buf_next;
         op_reg       <= op_next;
         addr_reg     <= addr_next;
         sdata_reg    <= sdata_next;
         rd_reg       <= rd_next;
         wreg_reg     <= wreg_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      byte_buf_next = byte_buf_reg;
      op_next       = op_reg;
      addr_next     = addr_reg;
      sdata_next    = sdata_reg;
      rd_next       = rd_reg;
      wreg_next     = wreg_reg;
      mctl_req      = 1'b0;
      mctl_wr       = 1'b0;
      mctl_addr     = ZERO_WORD;
      mctl_wdata    = 8'h00;
      mem_wreg      = WRITE_DISABLE;
      mem_rd        = 5'd0;
      mem_wdata     = ZERO_WORD;
      stall_req     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (ex_memop == MEMOP_NONE) begin
               mem_wreg  = ex_wreg;
               mem_rd    = ex_rd;
               mem_wdata = ex_result;
            end else begin
               stall_req     = 1'b1;
               op_next       = ex_memop;
               addr_next     = ex_result;
               sdata_next    = ex_storedata;
               rd_next       = ex_rd;
               wreg_next     = ex_wreg;
               idx_next      = 2'd0;
               byte_buf_next = ZERO_WORD;
               state_next    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // Request fields depend only on registered state, so they hold until ack.
            mctl_req   = 1'b1;
            mctl_wr    = is_store(op_reg);
            mctl_addr  = addr_reg + {30'd0, idx_reg};
            mctl_wdata = sdata_reg[{idx_reg, 3'b000} +: 8];
            stall_req  = 1'b1;
            if (mctl_ack) begin
               if (!is_store(op_reg)) begin
                  byte_buf_next[{idx_reg, 3'b000} +: 8] = mctl_rdata;
               end
               if (idx_reg == last_idx(op_reg)) begin
                  state_next = ST_DONE;
               end else begin
                  idx_next = idx_reg + 2'd1;
               end
            end
         end
         ST_DONE: begin
            if (!is_store(op_reg)) begin
               mem_wreg  = wreg_reg;
               mem_rd    = rd_reg;
               mem_wdata = load_value;
            end
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Reset forces every output quiet in the reset cycle itself.
      if (rst_in == RST_ENABLE) begin
         mctl_req   = 1'b0;
         mctl_wr    = 1'b0;
         mctl_addr  = ZERO_WORD;
         mctl_wdata = 8'h00;
         mem_wreg   = WRITE_DISABLE;
         mem_rd     = 5'd0;
         mem_wdata  = ZERO_WORD;
         stall_req  = 1'b0;
      end
   end

endmodule
